// File: rtl/dp_arbiter.sv
// Arbiter/sequencer sharing the s/y datapath between three requesters: one EXEC cycle of
// strobes, then HOLD_CYCLES settle cycles. Define DP_ARB_RR_EN for round-robin, else fixed priority.
module dp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] req,
  input  logic [5:0] op,
  input  logic [5:0] arg,
  output logic [2:0] ack,
  output logic [2:0] done,
  output logic       busy,
  output logic [1:0] owner,
  output logic       s_en,
  output logic       s_add,
  output logic       s_zero,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       y_store_x,
  output logic [1:0] y_select_next
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  localparam logic [2:0] HoldLoad = 3'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       grant, fin;
  logic [1:0] win, win_op, win_arg;

  logic       s_en_d, s_add_d, s_zero_d, y_en_d, y_store_x_d;
  logic [1:0] s_step_d, y_select_next_d;

  assign grant = (state_q == StIdle) && en && (|req);

`ifdef DP_ARB_RR_EN
  logic [1:0] rr_q;

  // Search starts one past the last winner and wraps over the three requesters.
  always_comb begin
    win = 2'd0;
    case (rr_q)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 2'd2;
    end else if (grant) begin
      rr_q <= win;
    end
  end
`else
  always_comb begin
    win = 2'd0;
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
  end
`endif

  always_comb begin
    win_op  = op[1:0];
    win_arg = arg[1:0];
    case (win)
      2'd1:    begin win_op = op[3:2]; win_arg = arg[3:2]; end
      2'd2:    begin win_op = op[5:4]; win_arg = arg[5:4]; end
      default: begin win_op = op[1:0]; win_arg = arg[1:0]; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    case (state_q)
      StIdle: if (grant) state_d = StExec;
      StExec: begin
        if (HOLD_CYCLES > 0) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          state_d = StIdle;
          fin     = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
          fin     = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded at the grant edge so later op/arg changes cannot reach them.
  always_comb begin
    s_en_d          = 1'b0;
    s_add_d         = 1'b0;
    s_zero_d        = 1'b0;
    s_step_d        = 2'd0;
    y_en_d          = 1'b0;
    y_store_x_d     = 1'b0;
    y_select_next_d = 2'd0;
    if (grant) begin
      case (win_op)
        2'd0: begin s_en_d = 1'b1; s_add_d  = 1'b1; s_step_d = win_arg; end
        2'd1: begin s_en_d = 1'b1; s_zero_d = 1'b1; s_step_d = win_arg; end
        2'd2: begin y_en_d = 1'b1; y_store_x_d = 1'b1; end
        default: begin y_en_d = 1'b1; y_select_next_d = win_arg; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      ack           <= 3'd0;
      done          <= 3'd0;
      busy          <= 1'b0;
      owner         <= 2'd0;
      s_en          <= 1'b0;
      s_add         <= 1'b0;
      s_zero        <= 1'b0;
      s_step        <= 2'd0;
      y_en          <= 1'b0;
      y_store_x     <= 1'b0;
      y_select_next <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ack           <= grant ? (3'b001 << win) : 3'b000;
      done          <= fin ? (3'b001 << owner) : 3'b000;
      busy          <= (state_d != StIdle);
      if (grant) owner <= win;
      s_en          <= s_en_d;
      s_add         <= s_add_d;
      s_zero        <= s_zero_d;
      s_step        <= s_step_d;
      y_en          <= y_en_d;
      y_store_x     <= y_store_x_d;
      y_select_next <= y_select_next_d;
    end
  end

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: three instances (HOLD_CYCLES 0, 1, 7), directed scenarios and a
// randomized run checked against a remaining-cycles reference model.
module tb_dp_arbiter;

  typedef struct packed {
    logic [2:0] ack;
    logic [2:0] done;
    logic       busy;
    logic [1:0] owner;
    logic       s_en;
    logic       s_add;
    logic       s_zero;
    logic [1:0] s_step;
    logic       y_en;
    logic       y_store_x;
    logic [1:0] y_select_next;
  } outs_t;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       en_a   [3];
  logic [2:0] req_a  [3];
  logic [5:0] op_a   [3];
  logic [5:0] arg_a  [3];
  logic [2:0] ack_a  [3];
  logic [2:0] done_a [3];
  logic       busy_a [3];
  logic [1:0] owner_a[3];
  logic       s_en_a [3];
  logic       s_add_a[3];
  logic       s_zero_a[3];
  logic [1:0] s_step_a[3];
  logic       y_en_a [3];
  logic       y_store_x_a[3];
  logic [1:0] y_select_next_a[3];

  int n_vec;
  int n_err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dp_arbiter #(
      .HOLD_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 7))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en_a[g]),
      .req          (req_a[g]),
      .op           (op_a[g]),
      .arg          (arg_a[g]),
      .ack          (ack_a[g]),
      .done         (done_a[g]),
      .busy         (busy_a[g]),
      .owner        (owner_a[g]),
      .s_en         (s_en_a[g]),
      .s_add        (s_add_a[g]),
      .s_zero       (s_zero_a[g]),
      .s_step       (s_step_a[g]),
      .y_en         (y_en_a[g]),
      .y_store_x    (y_store_x_a[g]),
      .y_select_next(y_select_next_a[g])
    );
  end

  // Reference model: an op occupies 1+HOLD busy cycles, then done shows in the next idle cycle.
  int    rem  [3];
  int    own_m[3];
  int    last_m[3];
  outs_t exp_m[3];

  function automatic int hold_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 7);
  endfunction

  function automatic outs_t get_obs(int i);
    outs_t o;
    o.ack = ack_a[i];             o.done = done_a[i];        o.busy = busy_a[i];
    o.owner = owner_a[i];         o.s_en = s_en_a[i];        o.s_add = s_add_a[i];
    o.s_zero = s_zero_a[i];       o.s_step = s_step_a[i];    o.y_en = y_en_a[i];
    o.y_store_x = y_store_x_a[i]; o.y_select_next = y_select_next_a[i];
    return o;
  endfunction

  function automatic int pick(int i);
    logic [2:0] r;
    r = req_a[i];
`ifdef DP_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      if (r[(last_m[i] + k) % 3]) return (last_m[i] + k) % 3;
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; own_m[i] = 0; last_m[i] = 2; exp_m[i] = '0;
    end
  endtask

  task automatic model_step(int i);
    outs_t e;
    int w;
    logic [1:0] opc, a;
    e = '0;
    if (rem[i] > 0) begin
      rem[i]--;
      if (rem[i] == 0) e.done = 3'(1 << own_m[i]);
    end else if (en_a[i] && req_a[i] != 3'b000) begin
      w = pick(i);
      own_m[i] = w; last_m[i] = w; rem[i] = 1 + hold_of(i);
      e.ack = 3'(1 << w);
      opc = op_a[i][2*w +: 2];
      a   = arg_a[i][2*w +: 2];
      case (opc)
        2'd0: begin e.s_en = 1'b1; e.s_add = 1'b1; e.s_step = a; end
        2'd1: begin e.s_en = 1'b1; e.s_zero = 1'b1; e.s_step = a; end
        2'd2: begin e.y_en = 1'b1; e.y_store_x = 1'b1; end
        default: begin e.y_en = 1'b1; e.y_select_next = a; end
      endcase
    end
    e.busy  = (rem[i] > 0);
    e.owner = 2'(own_m[i]);
    exp_m[i] = e;
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b1; req_a[i] = 3'b000; op_a[i] = 6'd0; arg_a[i] = 6'd0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    outs_t o;
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b1; req_a[i] = 3'b111; op_a[i] = 6'd0; arg_a[i] = 6'h3F;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      n_vec++;
      if (o !== '0) begin n_err++; $display("FAIL reset_async[%0d]: got %h want 0", i, o); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      n_vec++;
      if (o !== '0) begin n_err++; $display("FAIL reset_held[%0d]: got %h want 0", i, o); end
    end
  endtask

  task automatic test_single_op();
    outs_t o, e;
    do_reset();
    req_a[1] = 3'b001; op_a[1] = 6'b000000; arg_a[1] = 6'b000001;
    cyc();
    o = get_obs(1);
    e = '0; e.ack = 3'b001; e.busy = 1'b1; e.s_en = 1'b1; e.s_add = 1'b1; e.s_step = 2'd1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL single_exec: got %h want %h", o, e); end
    req_a[1] = 3'b000;
    cyc();
    o = get_obs(1);
    e = '0; e.busy = 1'b1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL single_hold: got %h want %h", o, e); end
    cyc();
    o = get_obs(1);
    e = '0; e.done = 3'b001;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL single_done: got %h want %h", o, e); end
  endtask

  task automatic test_all_req();
    outs_t o, e;
    int k;
    do_reset();
    op_a[1] = {2'd3, 2'd2, 2'd1}; arg_a[1] = {2'd3, 2'd0, 2'd2}; req_a[1] = 3'b111;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      o = get_obs(1);
      e = '0;
      if ((c - 1) % 3 == 0) begin
        k = (c - 1) / 3;
        e.ack = 3'(1 << k); e.busy = 1'b1; e.owner = 2'(k);
        if (k == 0) begin e.s_en = 1'b1; e.s_zero = 1'b1; e.s_step = 2'd2; end
        else if (k == 1) begin e.y_en = 1'b1; e.y_store_x = 1'b1; end
        else begin e.y_en = 1'b1; e.y_select_next = 2'd3; end
        req_a[1][k] = 1'b0;
      end else if (c % 3 == 2) begin
        e.busy = 1'b1; e.owner = 2'((c - 2) / 3);
      end else begin
        e.done = 3'(1 << (c / 3 - 1)); e.owner = 2'(c / 3 - 1);
      end
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL all_req c%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_starvation();
    logic [2:0] want;
    do_reset();
    req_a[1] = 3'b101;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      want = 3'b000;
      if (c == 1 || c == 7) want = 3'b001;
`ifdef DP_ARB_RR_EN
      if (c == 4) want = 3'b100;
`else
      if (c == 4) want = 3'b001;
`endif
      n_vec++;
      if (ack_a[1] !== want) begin
        n_err++; $display("FAIL starve_ack c%0d: got %b want %b", c, ack_a[1], want);
      end
      if (want == 3'b100) req_a[1][2] = 1'b0;
    end
    req_a[1] = 3'b000;
  endtask

  task automatic test_enable();
    outs_t o, e;
    do_reset();
    en_a[1] = 1'b0; req_a[1] = 3'b010; op_a[1] = 6'b001000;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      o = get_obs(1);
      n_vec++;
      if (o !== '0) begin n_err++; $display("FAIL en_blocked c%0d: got %h want 0", c, o); end
    end
    en_a[1] = 1'b1;
    cyc();
    o = get_obs(1);
    e = '0; e.ack = 3'b010; e.busy = 1'b1; e.owner = 2'd1; e.y_en = 1'b1; e.y_store_x = 1'b1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL en_grant: got %h want %h", o, e); end
    req_a[1] = 3'b000; en_a[1] = 1'b0;
    cyc();
    o = get_obs(1);
    e = '0; e.busy = 1'b1; e.owner = 2'd1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL en_hold: got %h want %h", o, e); end
    cyc();
    o = get_obs(1);
    e = '0; e.done = 3'b010; e.owner = 2'd1;
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL en_done: got %h want %h", o, e); end
    en_a[1] = 1'b1;
  endtask

  task automatic test_hold_extremes();
    outs_t o, e;
    int h;
    do_reset();
    for (int i = 0; i < 3; i += 2) begin
      req_a[i] = 3'b001; op_a[i] = 6'b000000; arg_a[i] = 6'b000001;
    end
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 1) begin
        for (int i = 0; i < 3; i += 2) begin op_a[i] = 6'h3F; arg_a[i] = 6'h2A; end
        #1;
      end
      for (int i = 0; i < 3; i += 2) begin
        h = hold_of(i);
        o = get_obs(i);
        e = '0;
        if (c == 1) begin
          e.ack = 3'b001; e.busy = 1'b1; e.s_en = 1'b1; e.s_add = 1'b1; e.s_step = 2'd1;
        end else if (c <= 1 + h) begin
          e.busy = 1'b1;
        end else if (c == 2 + h) begin
          e.done = 3'b001;
        end
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL hold%0d c%0d: got %h want %h", h, c, o, e); end
      end
      if (c == 1) begin req_a[0] = 3'b000; req_a[2] = 3'b000; end
    end
  endtask

  task automatic test_reset_mid_op();
    outs_t o, e;
    do_reset();
    req_a[2] = 3'b100; op_a[2] = 6'b010000;
    cyc();
    req_a[2] = 3'b000;
    cyc(); cyc();
    rst = 1'b1;
    model_reset();
    #1;
    o = get_obs(2);
    n_vec++;
    if (o !== '0) begin n_err++; $display("FAIL rst_mid: got %h want 0", o); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      o = get_obs(2);
      n_vec++;
      if (o !== '0) begin n_err++; $display("FAIL rst_no_done c%0d: got %h want 0", c, o); end
    end
    req_a[2] = 3'b100; arg_a[2] = 6'b110000;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      o = get_obs(2);
      e = '0; e.owner = 2'd2;
      if (c == 1) begin
        e.ack = 3'b100; e.busy = 1'b1; e.s_en = 1'b1; e.s_zero = 1'b1; e.s_step = 2'd3;
        req_a[2] = 3'b000;
      end else if (c <= 8) begin
        e.busy = 1'b1;
      end else begin
        e.done = 3'b100;
      end
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL rst_rerun c%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_random();
    outs_t o;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (exp_m[i].ack[j]) begin
            if ($urandom_range(1) == 0) begin
              req_a[i][j] = 1'b0;
            end else begin
              op_a[i][2*j +: 2]  = 2'($urandom_range(3));
              arg_a[i][2*j +: 2] = 2'($urandom_range(3));
            end
          end else if (!req_a[i][j]) begin
            op_a[i][2*j +: 2]  = 2'($urandom_range(3));
            arg_a[i][2*j +: 2] = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) req_a[i][j] = 1'b1;
          end else if ($urandom_range(31) == 0) begin
            req_a[i][j] = 1'b0;
          end
        end
        en_a[i] = ($urandom_range(7) != 0);
      end
      cyc();
      for (int i = 0; i < 3; i++) begin
        o = get_obs(i);
        n_vec++;
        if (o !== exp_m[i]) begin
          n_err++; $display("FAIL random[%0d] n%0d: got %h want %h", i, n, o, exp_m[i]);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_op();
    test_all_req();
    test_starvation();
    test_enable();
    test_hold_extremes();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dp_arbiter.md
# dp_arbiter

Arbiter and sequencer that shares the s/y datapath (s counter with step/add/zero controls, y register with store-x/select-next controls) between three command requesters. Requesters include the count tick, update and list-scan logic. Each requester posts a 2-bit opcode and a 2-bit argument with a req/ack/done handshake. The arbiter grants one requester at a time, drives the datapath control strobes for exactly one cycle, then holds the datapath idle for a programmable settle time before the next grant.

## Interface
- HOLD_CYCLES, 1, settle cycles after each executed op (0..7)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  grant enable; 0 blocks new grants, an op in flight completes
- req  in  3  per-requester request, bit i = requester i
- op  in  6  opcodes, op[2i+1:2i] for requester i
- arg  in  6  arguments, arg[2i+1:2i] for requester i
- ack  out  1x3  one-cycle pulse per requester, op accepted (EXEC cycle)
- done  out  3  one-cycle pulse per requester, op and settle complete
- busy  out  1  high in EXEC and HOLD
- owner  out  2  index of current or last granted requester
- s_en, s_add, s_zero  out  1 each  s counter controls
- s_step  out  2  s counter step
- y_en, y_store_x  out  1 each  y register controls
- y_select_next  out  2  y next-value select

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE: if en=1 and any req bit is high, pick a winner (see Configuration). Latch the winner's op/arg and set owner. Next state is EXEC.
- EXEC (exactly 1 cycle): drive the strobes decoded from the latched op. Pulse ack[owner]. Next state is HOLD if HOLD_CYCLES>0, else IDLE.
- HOLD: all strobes 0. Counter loads HOLD_CYCLES-1 and counts down. Leave for IDLE when it reaches 0.
- done[owner] pulses in the first IDLE cycle after the op completes. A new grant decision is made in that same cycle.
- Opcode decode in EXEC; every strobe not listed is 0:
  - 0 S_ADD: s_en=1, s_add=1, s_zero=0, s_step=arg.
  - 1 S_LOAD: s_en=1, s_add=0, s_zero=1, s_step=arg.
  - 2 Y_STORE: y_en=1, y_store_x=1.
  - 3 Y_SELECT: y_en=1, y_store_x=0, y_select_next=arg.
- Outside EXEC, all strobes are 0 and s_step = y_select_next = 0.
- Requester rules:
  - Hold req, op and arg stable until ack.
  - Drop req in or after the ack cycle unless it wants another op.
  - A req still high after done is treated as a new request.
  - A req dropped before grant is never executed; no ack, no done.
- en=0 in HOLD or EXEC has no effect on the current op. Its done still pulses.
- Reset:
  - Outputs: ack=0, done=0, busy=0, owner=0, all strobes 0.
  - Internal: state IDLE, round-robin pointer = 2, so requester 0 is first in order.
  - Reset mid-op aborts the op and no done is issued.

## Timing
- All outputs are registered.
- Grant latency: req seen high in IDLE at edge t gives EXEC/ack/strobes in cycle t+1.
- done appears in cycle t+2+HOLD_CYCLES.
- Throughput: one op per 2+HOLD_CYCLES cycles under continuous demand.
- Latched op/arg are immune to op/arg changes after the grant edge.
- busy is high from EXEC through the last HOLD cycle and low in the done cycle.

## Configuration
- DP_ARB_RR_EN defined: round-robin arbitration.
  - Search order starts at (last owner + 1) mod 3 and wraps, skipping index 3.
  - The pointer updates at each grant.
- DP_ARB_RR_EN undefined: fixed priority, req[0] > req[1] > req[2]. The pointer is not implemented.

## Test plan
- Single op, HOLD_CYCLES=1: req=001, op0=0, arg0=1 at cycle 0.
  - Cycle 1: ack=001, s_en=1, s_add=1, s_step=1.
  - Cycle 2: HOLD, strobes 0.
  - Cycle 3: done=001, busy=0.
- All requesters, ops 1/2/3, args 2/0/3, req=111 held until each ack:
  - With DP_ARB_RR_EN, grants are 0,1,2 at cycles 1,4,7. Y_SELECT shows y_en=1, y_select_next=3.
  - Without it, same order; re-asserting req0 after its done preempts req2.
- Starvation check with DP_ARB_RR_EN: req0 re-requests continuously with req2 pending. req2 is granted no later than the second grant after req0's first.
- en=0 while req=010: no ack for 10 cycles. Raise en, then ack=010 next cycle. Drop en during HOLD: done still pulses.
- HOLD_CYCLES=0 and HOLD_CYCLES=7: done at cycle 2 and cycle 9 after a req at cycle 0. The op/arg change after ack does not alter the strobes.
- Assert rst during HOLD: busy, owner and strobes go 0 immediately. No done follows. The next req executes normally from IDLE.
